// File: rtl/gtrg_rdout_seq_if.sv
// Handshake/bus bundle between the GTRG FIFO, the readout sources and the
// readout sequencer. The slave modport is the sequencer's view.
interface gtrg_rdout_seq_if;
    logic        EMPTY_B;
    logic [16:0] DAVSOUT;
    logic [11:0] BXCOUNTOUT;
    logic        RDY;
    logic [6:0]  SKIP;
    logic [6:0]  DONE;
    logic        POP;
    logic        BUSY;
    logic        HDR;
    logic        TRL;
    logic [11:0] EVT_BX;
    logic [6:0]  EVT_MASK;
    logic [6:0]  RDREQ;
    logic [6:0]  TOERR;
    logic [15:0] EVTCNT;
    logic [7:0]  TOCNT;

    modport slave (
        input  EMPTY_B, DAVSOUT, BXCOUNTOUT, RDY, SKIP, DONE,
        output POP, BUSY, HDR, TRL, EVT_BX, EVT_MASK, RDREQ, TOERR, EVTCNT, TOCNT
    );

    modport master (
        output EMPTY_B, DAVSOUT, BXCOUNTOUT, RDY, SKIP, DONE,
        input  POP, BUSY, HDR, TRL, EVT_BX, EVT_MASK, RDREQ, TOERR, EVTCNT, TOCNT
    );
endinterface

// File: rtl/gtrg_rdout_seq.sv
// GTRG readout sequencer: pops one trigger entry, frames it with header and
// trailer strobes and walks the flagged sources with a req/done handshake.
module gtrg_rdout_seq #(
    parameter int TIMEOUT = 255,
    parameter int SETTLE  = 2
) (
    input logic             CLK,
    input logic             RST,
    gtrg_rdout_seq_if.slave bus
);

    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SCAN,
        S_REQ,
        S_TRL
    } state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_pend, r_cur, r_mask, r_toerr;
    logic [11:0] r_bx;
    logic [7:0]  r_tcnt, r_tocnt;
    logic [15:0] r_evtcnt;
    logic [SW-1:0] r_settle;

    logic        w_pop, w_done_hit, w_to_hit;
    logic [6:0]  w_pick, w_mask;
    logic        w_unused;

    // ALCT first, then TMB, then CFEB1 (bit 0) upward to CFEB5 (bit 4)
    function automatic logic [6:0] pick(input logic [6:0] p);
        logic [6:0] oh;
        oh = '0;
        if (p[6])
            oh = 7'h40;
        else if (p[5])
            oh = 7'h20;
        else
            for (int i = 4; i >= 0; i--)
                if (p[i]) oh = 7'b1 << i;
        return oh;
    endfunction

    assign w_mask     = {bus.DAVSOUT[16], bus.DAVSOUT[0], bus.DAVSOUT[5:1]} & ~bus.SKIP;
    assign w_pick     = pick(r_pend);
    assign w_done_hit = |(bus.DONE & r_cur);
    assign w_to_hit   = (r_tcnt == 8'(TIMEOUT - 1));
    assign w_unused   = ^bus.DAVSOUT[15:6];

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.EMPTY_B && bus.RDY && (r_settle == '0)) begin
                    w_pop  = 1'b1;
                    w_next = S_HDR;
                end
            end
            S_HDR:  w_next = S_SCAN;
            S_SCAN: w_next = (r_pend == '0) ? S_TRL : S_REQ;
            S_REQ:  if (w_done_hit || w_to_hit) w_next = S_SCAN;
            S_TRL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_pend   <= '0;
            r_cur    <= '0;
            r_mask   <= '0;
            r_toerr  <= '0;
            r_bx     <= '0;
            r_tcnt   <= '0;
            r_tocnt  <= '0;
            r_evtcnt <= '0;
            r_settle <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_bx     <= bus.BXCOUNTOUT;
                r_mask   <= w_mask;
                r_pend   <= w_mask;
                r_toerr  <= '0;
                r_settle <= SW'(SETTLE);
            end else if (r_settle != '0) begin
                r_settle <= r_settle - SW'(1);
            end
            if (r_state == S_SCAN) begin
                r_cur  <= w_pick;
                r_tcnt <= '0;
            end
            // DONE outranks a timeout landing on the same cycle
            if (r_state == S_REQ) begin
                if (w_done_hit) begin
                    r_pend <= r_pend & ~r_cur;
                end else if (w_to_hit) begin
                    r_pend  <= r_pend & ~r_cur;
                    r_toerr <= r_toerr | r_cur;
                    if (r_tocnt != 8'hFF) r_tocnt <= r_tocnt + 8'd1;
                end else begin
                    r_tcnt <= r_tcnt + 8'd1;
                end
            end
            if (r_state == S_TRL) r_evtcnt <= r_evtcnt + 16'd1;
        end
    end

    // POP is decoded from IDLE, so it is held off explicitly while reset is high
    assign bus.POP      = w_pop && !RST;
    assign bus.BUSY     = (r_state != S_IDLE);
    assign bus.HDR      = (r_state == S_HDR);
    assign bus.TRL      = (r_state == S_TRL);
    assign bus.RDREQ    = (r_state == S_REQ) ? r_cur : 7'h00;
    assign bus.EVT_BX   = r_bx;
    assign bus.EVT_MASK = r_mask;
    assign bus.TOERR    = r_toerr;
    assign bus.EVTCNT   = r_evtcnt;
    assign bus.TOCNT    = r_tocnt;

endmodule

// File: tb/tb_gtrg_rdout_seq.sv
// Bench for gtrg_rdout_seq: event-trace model with per-cycle compare, plus
// directed scenarios pinned by hand-computed literals.
module tb_gtrg_rdout_seq;

    localparam int TIMEOUT = 255;
    localparam int SETTLE  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gtrg_rdout_seq_if bus ();
    gtrg_rdout_seq #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 60) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO feeding the DUT
    typedef struct packed {
        logic [16:0] dav;
        logic [11:0] bx;
    } ent_t;
    ent_t fq[$];
    logic pop_pend = 1'b0;

    function automatic void drive_bus();
        bus.EMPTY_B    = (fq.size() > 0);
        bus.DAVSOUT    = (fq.size() > 0) ? fq[0].dav : 17'h0;
        bus.BXCOUNTOUT = (fq.size() > 0) ? fq[0].bx  : 12'h0;
    endfunction

    always @(negedge clk) if (!rst && bus.POP) pop_pend = 1'b1;
    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            fq.delete(0);
            pop_pend = 1'b0;
        end
        drive_bus();
    end

    // Source responder: DONE after dly[k] request cycles, 0 = never answers
    int dly[7];
    logic [6:0] noise = 7'h00;
    int hold = 0;

    function automatic int idx(input logic [6:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 7; i++) if (oh[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.RDREQ != 7'h00) begin
            hold++;
            bus.DONE = ((dly[idx(bus.RDREQ)] != 0 && hold == dly[idx(bus.RDREQ)]) ? bus.RDREQ : 7'h00)
                       | (noise & ~bus.RDREQ);
        end else begin
            hold = 0;
            bus.DONE = noise;
        end
    end

    // Model: on each pop, the whole event is expanded into a per-cycle trace
    typedef struct packed {
        logic       hdr;
        logic       trl;
        logic [6:0] rq;
        logic       to;
    } step_t;
    step_t tq[$];
    logic [11:0] m_bx     = '0;
    logic [6:0]  m_mask   = '0;
    logic [6:0]  m_toerr  = '0;
    logic [7:0]  m_tocnt  = '0;
    logic [15:0] m_evtcnt = '0;
    int mcyc = 0;
    int last_pop = -100;

    function automatic step_t mk(input logic h, input logic t, input logic [6:0] rq, input logic to);
        step_t s;
        s.hdr = h; s.trl = t; s.rq = rq; s.to = to;
        return s;
    endfunction

    function automatic void build(input logic [6:0] mask);
        int order[7] = '{6, 5, 0, 1, 2, 3, 4};
        int n;
        logic tmo;
        tq.push_back(mk(1'b1, 1'b0, 7'h00, 1'b0));
        foreach (order[i]) begin
            if (mask[order[i]]) begin
                tq.push_back(mk(1'b0, 1'b0, 7'h00, 1'b0));
                tmo = (dly[order[i]] == 0) || (dly[order[i]] > TIMEOUT);
                n   = tmo ? TIMEOUT : dly[order[i]];
                for (int j = 0; j < n; j++)
                    tq.push_back(mk(1'b0, 1'b0, 7'b1 << order[i], tmo && (j == n - 1)));
            end
        end
        tq.push_back(mk(1'b0, 1'b0, 7'h00, 1'b0));
        tq.push_back(mk(1'b0, 1'b1, 7'h00, 1'b0));
    endfunction

    task automatic chk_regs();
        chk("evt_bx", bus.EVT_BX, m_bx);
        chk("evt_mask", bus.EVT_MASK, m_mask);
        chk("toerr", bus.TOERR, m_toerr);
        chk("tocnt", bus.TOCNT, m_tocnt);
        chk("evtcnt", bus.EVTCNT, m_evtcnt);
    endtask

    always @(negedge clk) begin
        step_t s;
        logic  exp_pop;
        mcyc++;
        if (rst) begin
            tq.delete();
            m_bx = '0; m_mask = '0; m_toerr = '0; m_tocnt = '0; m_evtcnt = '0;
            last_pop = -100;
            chk("rst_pop", bus.POP, 0);
            chk("rst_busy", bus.BUSY, 0);
            chk("rst_hdr", bus.HDR, 0);
            chk("rst_trl", bus.TRL, 0);
            chk("rst_rdreq", bus.RDREQ, 0);
            chk_regs();
        end else if (tq.size() > 0) begin
            s = tq.pop_front();
            chk("busy", bus.BUSY, 1);
            chk("pop_busy", bus.POP, 0);
            chk("hdr", bus.HDR, s.hdr);
            chk("trl", bus.TRL, s.trl);
            chk("rdreq", bus.RDREQ, s.rq);
            chk_regs();
            if (s.to) begin
                m_toerr |= s.rq;
                if (m_tocnt != 8'hFF) m_tocnt++;
            end
            if (s.trl) m_evtcnt++;
        end else begin
            exp_pop = bus.EMPTY_B && bus.RDY && (mcyc - last_pop > SETTLE);
            chk("pop", bus.POP, exp_pop);
            chk("idle_busy", bus.BUSY, 0);
            chk("idle_hdr", bus.HDR, 0);
            chk("idle_trl", bus.TRL, 0);
            chk("idle_rdreq", bus.RDREQ, 0);
            chk_regs();
            if (exp_pop) begin
                last_pop = mcyc;
                m_bx     = bus.BXCOUNTOUT;
                m_mask   = {bus.DAVSOUT[16], bus.DAVSOUT[0], bus.DAVSOUT[5:1]} & ~bus.SKIP;
                m_toerr  = '0;
                build(m_mask);
            end
        end
    end

    // Recorder of observed strobes and request runs for the literal checks
    int lcyc = 0;
    int pop_q[$];
    int hdr_at = -1, trl_at = -1, first_rq = -1, trl_cnt = 0;
    logic [6:0] prev_rq = 7'h00;
    int rq_len = 0;
    logic [6:0] rq_val[$];
    int rq_n[$];

    always @(negedge clk) begin
        lcyc++;
        if (!rst) begin
            if (bus.POP) pop_q.push_back(lcyc);
            if (bus.HDR) hdr_at = lcyc;
            if (bus.TRL) begin trl_at = lcyc; trl_cnt++; end
            if (bus.RDREQ != 7'h00 && first_rq < 0) first_rq = lcyc;
        end
        if (bus.RDREQ != 7'h00 && bus.RDREQ == prev_rq) begin
            rq_len++;
        end else begin
            if (prev_rq != 7'h00) begin
                rq_val.push_back(prev_rq);
                rq_n.push_back(rq_len);
            end
            rq_len = (bus.RDREQ != 7'h00) ? 1 : 0;
        end
        prev_rq = bus.RDREQ;
    end

    task automatic cyc_t();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_rec();
        pop_q.delete(); rq_val.delete(); rq_n.delete();
        hdr_at = -1; trl_at = -1; first_rq = -1; trl_cnt = 0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            cyc_t();
            n++;
        end while ((tq.size() != 0 || fq.size() != 0) && n < budget);
        chk({nm, "_done_in_budget"}, (n < budget), 1);
        cyc_t();
    endtask

    task automatic chk_run(input string nm, input int i, input logic [6:0] v, input int len);
        chk({nm, "_rq_val"}, (rq_val.size() > i) ? rq_val[i] : 7'h7F, v);
        chk({nm, "_rq_len"}, (rq_n.size() > i) ? rq_n[i] : -1, len);
    endtask

    initial begin
        bus.RDY  = 1'b0;
        bus.SKIP = 7'h00;
        bus.DONE = 7'h00;
        drive_bus();
        for (int i = 0; i < 7; i++) dly[i] = 3;
        repeat (3) cyc_t();
        chk("init_evtcnt", bus.EVTCNT, 0);
        chk("init_busy", bus.BUSY, 0);
        rst = 1'b0;
        cyc_t();

        // Three-source event, unrelated DONE noise on other bits
        clr_rec();
        noise   = 7'h13;
        bus.RDY = 1'b1;
        fq.push_back('{dav: 17'h10009, bx: 12'h123});
        drive_bus();
        wait_idle("t1", 100);
        noise = 7'h00;
        chk("t1_hdr_lat", hdr_at - ((pop_q.size() > 0) ? pop_q[0] : 0), 1);
        chk("t1_rq_lat", first_rq - ((pop_q.size() > 0) ? pop_q[0] : 0), 3);
        chk("t1_nruns", rq_val.size(), 3);
        chk_run("t1a", 0, 7'h40, 3);
        chk_run("t1b", 1, 7'h20, 3);
        chk_run("t1c", 2, 7'h04, 3);
        chk("t1_bx", bus.EVT_BX, 12'h123);
        chk("t1_mask", bus.EVT_MASK, 7'h64);
        chk("t1_evtcnt", bus.EVTCNT, 1);

        // Empty mask: POP, HDR, SCAN, TRL
        clr_rec();
        fq.push_back('{dav: 17'h00000, bx: 12'h456});
        drive_bus();
        wait_idle("t2", 30);
        chk("t2_trl_lat", trl_at - ((pop_q.size() > 0) ? pop_q[0] : 0), 3);
        chk("t2_nruns", rq_val.size(), 0);
        chk("t2_mask", bus.EVT_MASK, 7'h00);
        chk("t2_bx", bus.EVT_BX, 12'h456);
        chk("t2_evtcnt", bus.EVTCNT, 2);

        // ALCT never answers
        clr_rec();
        dly[6] = 0;
        fq.push_back('{dav: 17'h10000, bx: 12'h789});
        drive_bus();
        wait_idle("t3", 400);
        chk_run("t3", 0, 7'h40, 255);
        chk("t3_toerr", bus.TOERR, 7'h40);
        chk("t3_tocnt", bus.TOCNT, 1);
        chk("t3_evtcnt", bus.EVTCNT, 3);
        dly[6] = 3;

        // TMB answers on the timeout cycle; CFEB2 skipped, SKIP released mid-event
        clr_rec();
        dly[5]   = 255;
        bus.SKIP = 7'h02;
        fq.push_back('{dav: 17'h00005, bx: 12'h0AB});
        drive_bus();
        repeat (4) cyc_t();
        bus.SKIP = 7'h00;
        wait_idle("t4", 400);
        chk("t4_nruns", rq_val.size(), 1);
        chk_run("t4", 0, 7'h20, 255);
        chk("t4_toerr", bus.TOERR, 7'h00);
        chk("t4_tocnt", bus.TOCNT, 1);
        chk("t4_mask", bus.EVT_MASK, 7'h20);
        dly[5] = 3;

        // RDY low blocks POP; then back-to-back entries
        clr_rec();
        for (int i = 0; i < 7; i++) dly[i] = 2;
        bus.RDY = 1'b0;
        fq.push_back('{dav: 17'h00002, bx: 12'hA01});
        fq.push_back('{dav: 17'h00020, bx: 12'hA02});
        drive_bus();
        repeat (6) cyc_t();
        chk("t5_rdy_block", pop_q.size(), 0);
        bus.RDY = 1'b1;
        wait_idle("t5", 100);
        chk("t5_npop", pop_q.size(), 2);
        chk("t5_gap", (pop_q.size() > 1) ? pop_q[1] - pop_q[0] : 0, 7);
        chk_run("t5a", 0, 7'h01, 2);
        chk_run("t5b", 1, 7'h10, 2);
        chk("t5_bx", bus.EVT_BX, 12'hA02);
        chk("t5_mask", bus.EVT_MASK, 7'h10);
        chk("t5_evtcnt", bus.EVTCNT, 6);

        // Asynchronous reset while a request is outstanding
        clr_rec();
        dly[6] = 0;
        fq.push_back('{dav: 17'h10000, bx: 12'h111});
        drive_bus();
        begin
            int n;
            n = 0;
            while (bus.RDREQ == 7'h00 && n < 20) begin cyc_t(); n++; end
            chk("t6_rdreq_seen", bus.RDREQ, 7'h40);
        end
        repeat (5) cyc_t();
        #1 rst = 1'b1;
        #1;
        chk("t6_rdreq", bus.RDREQ, 0);
        chk("t6_busy", bus.BUSY, 0);
        chk("t6_evtcnt", bus.EVTCNT, 0);
        chk("t6_bx", bus.EVT_BX, 0);
        repeat (2) cyc_t();
        rst = 1'b0;
        repeat (8) cyc_t();
        chk("t6_no_trl", trl_cnt, 0);
        chk("t6_npop", pop_q.size(), 1);
        chk("t6_idle", bus.BUSY, 0);
        chk("t6_evtcnt_after", bus.EVTCNT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
